// File: rtl/rpn_eval.sv
// Postfix (RPN) evaluator: unpacks 19 five-bit tokens, one per cycle, onto an operand stack.
// Define RPN_DIV_EN to build the signed divider; without it '/' yields 0 and flags an error.
module rpn_eval #(
    parameter int unsigned DATA_W  = 41,
    parameter int unsigned STACK_D = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [94:0]       in_rpn,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out,
    output logic              out_err
);

    localparam int unsigned DEPTH_W = $clog2(STACK_D + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_D);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e              state_q, state_d;
    logic [94:0]         shift_q, shift_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   stack_q [STACK_D];
    logic [DATA_W-1:0]   stack_d [STACK_D];
    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                out_err_q, out_err_d;

    logic [4:0]          tok;
    logic                tok_illegal;
    logic [DEPTH_W-1:0]  idx_a, idx_b;
    logic signed [DATA_W-1:0] opnd_a, opnd_b, alu_res;
    logic                alu_err;

    assign tok         = shift_q[94:90];
    assign tok_illegal = tok[4] && (tok[3:2] != 2'b00);

    // Indices are clamped so the stack is never read out of range when underflowing.
    assign idx_b  = (depth_q >= DEPTH_TWO) ? depth_q - DEPTH_ONE : '0;
    assign idx_a  = (depth_q >= DEPTH_TWO) ? depth_q - DEPTH_TWO : '0;
    assign opnd_a = stack_q[idx_a];
    assign opnd_b = stack_q[idx_b];

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        unique case (tok[1:0])
            2'b00: alu_res = opnd_a + opnd_b;
            2'b01: alu_res = opnd_a - opnd_b;
            2'b10: alu_res = opnd_a * opnd_b;
            default: begin
`ifdef RPN_DIV_EN
                if (opnd_b == '0) begin
                    alu_err = 1'b1;
                end else begin
                    alu_res = opnd_a / opnd_b;
                end
`else
                alu_err = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        depth_d     = depth_q;
        err_d       = err_q;
        stack_d     = stack_q;
        out_d       = '0;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_d = in_rpn;
                    cnt_d   = '0;
                    depth_d = '0;
                    err_d   = 1'b0;
                    state_d = StEval;
                end
            end
            StEval: begin
                shift_d = {shift_q[89:0], 5'b0};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd18) begin
                    state_d = StDone;
                end
                if (!tok[4]) begin
                    if (depth_q == DEPTH_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        stack_d[depth_q] = {{(DATA_W-4){1'b0}}, tok[3:0]};
                        depth_d          = depth_q + DEPTH_ONE;
                    end
                end else if (tok_illegal || depth_q < DEPTH_TWO) begin
                    err_d = 1'b1;
                end else begin
                    stack_d[idx_a] = alu_res;
                    depth_d        = depth_q - DEPTH_ONE;
                    if (alu_err) begin
                        err_d = 1'b1;
                    end
                end
            end
            StDone: begin
                out_valid_d = 1'b1;
                state_d     = StIdle;
                if (depth_q != DEPTH_ONE || err_q) begin
                    out_err_d = 1'b1;
                end else begin
                    out_d = stack_q[0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            cnt_q       <= '0;
            depth_q     <= '0;
            err_q       <= 1'b0;
            stack_q     <= '{default: '0};
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            stack_q     <= stack_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    // Busy also covers the result cycle, when the FSM has already returned to idle.
    assign busy      = (state_q != StIdle) || out_valid_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_rpn_eval.sv
// Directed self-checking bench for rpn_eval; expected values are hand-computed constants.
module tb_rpn_eval;

    localparam int unsigned DW = 41;
    localparam logic [4:0] ADD = 5'b10000;
    localparam logic [4:0] SUB = 5'b10001;
    localparam logic [4:0] MUL = 5'b10010;
    localparam logic [4:0] DIV = 5'b10011;
    localparam logic [4:0] ILL = 5'b10100;
    localparam logic [9:0] PAD = {5'd0, ADD};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [94:0]   in_rpn = '0;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] out;
    logic          out_err;

    int n_checks = 0;
    int n_errors = 0;

    rpn_eval #(.DATA_W(DW), .STACK_D(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_rpn    (in_rpn),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Drives one expression; returns edges from acceptance to out_valid (40 = timed out).
    task automatic run_expr(input logic [94:0] rpn, output int lat,
                            output logic [DW-1:0] res, output logic err);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_rpn   = rpn;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out;
        err = out_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out !== '0 || out_err !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: valid=%b out=%0d err=%b busy=%b, want 0 0 0 0",
                     out_valid, out, out_err, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sum();
        int lat;
        logic [DW-1:0] res;
        logic err;
        run_expr({5'd1, 5'd2, ADD, 5'd3, ADD, 5'd4, ADD, 5'd5, ADD, 5'd6, ADD,
                  5'd7, ADD, 5'd8, ADD, 5'd9, ADD, 5'd10, ADD}, lat, res, err);
        n_checks++;
        if (lat !== 21) begin
            n_errors++;
            $display("FAIL sum_latency: got %0d want 21", lat);
        end
        n_checks++;
        if (res !== 41'd55 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL sum_result: got %0d err=%b want 55 err=0", res, err);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out !== '0 || out_err !== 1'b0) begin
            n_errors++;
            $display("FAIL sum_pulse_end: valid=%b out=%0d err=%b want 0 0 0",
                     out_valid, out, out_err);
        end
    endtask

    task automatic test_arith();
        int lat;
        logic [DW-1:0] res;
        logic err;
        run_expr({5'd15, {9{5'd15, MUL}}}, lat, res, err);
        n_checks++;
        if (res !== 41'd576650390625 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL wide_mul: got %0d err=%b want 576650390625 err=0", res, err);
        end
        run_expr({5'd9, 5'd3, SUB, 5'd4, MUL, {7{PAD}}}, lat, res, err);
        n_checks++;
        if (res !== 41'd24 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL sub_mul: got %0d err=%b want 24 err=0", res, err);
        end
        run_expr({5'd0, 5'd1, SUB, {8{PAD}}}, lat, res, err);
        n_checks++;
        if (res !== {DW{1'b1}} || err !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_neg1: got %h err=%b want %h err=0", res, err, {DW{1'b1}});
        end
        run_expr({{10{5'd1}}, {9{ADD}}}, lat, res, err);
        n_checks++;
        if (res !== 41'd10 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL full_stack: got %0d err=%b want 10 err=0", res, err);
        end
    endtask

    task automatic test_divide();
        int lat;
        logic [DW-1:0] res;
        logic err;
        logic [DW-1:0] want_res;
        logic want_err;
`ifdef RPN_DIV_EN
        want_res = -41'sd3;
        want_err = 1'b0;
`else
        want_res = '0;
        want_err = 1'b1;
`endif
        run_expr({5'd0, 5'd7, SUB, 5'd2, DIV, {7{PAD}}}, lat, res, err);
        n_checks++;
        if (res !== want_res || err !== want_err) begin
            n_errors++;
            $display("FAIL signed_div: got %h err=%b want %h err=%b", res, err, want_res,
                     want_err);
        end
        run_expr({5'd15, 5'd0, DIV, {8{PAD}}}, lat, res, err);
        n_checks++;
        if (res !== '0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL div_zero: got %0d err=%b want 0 err=1", res, err);
        end
    endtask

    task automatic test_errors();
        int lat;
        logic [DW-1:0] res;
        logic err;
        run_expr({ADD, ADD, 5'd1, {8{PAD}}}, lat, res, err);
        n_checks++;
        if (res !== '0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL underflow: got %0d err=%b want 0 err=1", res, err);
        end
        run_expr({19{5'd1}}, lat, res, err);
        n_checks++;
        if (res !== '0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow: got %0d err=%b want 0 err=1", res, err);
        end
        run_expr({5'd1, ILL, ILL, {8{PAD}}}, lat, res, err);
        n_checks++;
        if (res !== '0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_tok: got %0d err=%b want 0 err=1", res, err);
        end
        // A clean expression right after errors shows the flag does not leak across runs.
        run_expr({5'd2, 5'd3, MUL, {8{PAD}}}, lat, res, err);
        n_checks++;
        if (res !== 41'd6 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_cleared: got %0d err=%b want 6 err=0", res, err);
        end
    endtask

    task automatic test_busy();
        int n_pulse = 0;
        int first = 0;
        logic busy1 = 1'b0;
        logic busy21 = 1'b0;
        logic busy22 = 1'b1;
        logic [DW-1:0] res = '0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_rpn   = {5'd4, 5'd5, MUL, {8{PAD}}};
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
            if (k == 5) begin
                in_valid = 1'b1;
                in_rpn   = {5'd1, {9{5'd1, ADD}}};
            end
            if (k == 6) in_valid = 1'b0;
            if (k == 1) busy1 = busy;
            if (k == 21) busy21 = busy;
            if (k == 22) busy22 = busy;
            if (out_valid) begin
                n_pulse++;
                if (first == 0) begin
                    first = k;
                    res = out;
                end
            end
        end
        n_checks++;
        if (n_pulse !== 1 || first !== 21) begin
            n_errors++;
            $display("FAIL busy_ignore: pulses=%0d at %0d want 1 at 21", n_pulse, first);
        end
        n_checks++;
        if (res !== 41'd20) begin
            n_errors++;
            $display("FAIL busy_result: got %0d want 20", res);
        end
        n_checks++;
        if (busy1 !== 1'b1 || busy21 !== 1'b1 || busy22 !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_window: T+1=%b T+21=%b T+22=%b want 1 1 0",
                     busy1, busy21, busy22);
        end
    endtask

    task automatic test_abort();
        int n_pulse = 0;
        int lat;
        logic [DW-1:0] res;
        logic err;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_rpn   = {5'd1, {9{5'd1, ADD}}};
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
            if (k == 10) begin
                rst_n = 1'b0;
                #2;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL abort_busy: got %b want 0", busy);
                end
                rst_n = 1'b1;
            end
            if (out_valid) n_pulse++;
        end
        n_checks++;
        if (n_pulse !== 0) begin
            n_errors++;
            $display("FAIL abort_no_out: pulses=%0d want 0", n_pulse);
        end
        run_expr({5'd7, 5'd8, ADD, {8{PAD}}}, lat, res, err);
        n_checks++;
        if (lat !== 21 || res !== 41'd15 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_recover: lat=%0d got %0d err=%b want 21 15 0", lat, res, err);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        logic [DW-1:0] res_a;
        logic [DW-1:0] res_b;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_rpn   = {5'd6, 5'd6, MUL, {8{PAD}}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        res_a = out;
        // Cycle T+21: result is on the outputs and the next expression is offered.
        in_valid = 1'b1;
        in_rpn   = {5'd9, 5'd2, SUB, {8{PAD}}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res_b = out;
        n_checks++;
        if (res_a !== 41'd36) begin
            n_errors++;
            $display("FAIL b2b_first: got %0d want 36", res_a);
        end
        n_checks++;
        if (lat !== 21 || res_b !== 41'd7) begin
            n_errors++;
            $display("FAIL b2b_second: lat=%0d got %0d want 21 7", lat, res_b);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sum();
        test_arith();
        test_divide();
        test_errors();
        test_busy();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
